// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: single-port memory read side plus the
// instruction valid/ready handshake toward decode.
interface fetch_unit_if;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        mem_data_valid;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      output mem_wr, mem_addr, mem_data_in, instr_valid, instr, instr_pc,
      input  mem_data_out, mem_data_valid, instr_ready
   );

   modport slave (
      input  mem_wr, mem_addr, mem_data_in, instr_valid, instr, instr_pc,
      output mem_data_out, mem_data_valid, instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch requester: issues word reads from the PC, buffers returned
// words in a small shift FIFO and hands them to decode; redirect flushes everything.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_2000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc
);
   localparam int unsigned   CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {HOLD, ISSUE, WAIT} state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   fifo_instr_q [DEPTH];
   logic [31:0]   fifo_instr_d [DEPTH];
   logic [31:0]   fifo_pc_q    [DEPTH];
   logic [31:0]   fifo_pc_d    [DEPTH];

   logic          pop;
   logic          push;
   logic [CW-1:0] count_after_pop;
   logic [CW-1:0] count_after;
   logic          unused_rpc_bits;

   assign unused_rpc_bits = ^redirect_pc[1:0];

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      count_d      = count_q;
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;

      pop             = (count_q != '0) && bus.instr_ready;
      // A response is only trusted in WAIT; in ISSUE/HOLD the valid may belong to an older read.
      push            = (state_q == WAIT) && bus.mem_data_valid;
      count_after_pop = count_q - CW'(pop);
      count_after     = count_after_pop + CW'(push);

      if (pop) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            fifo_instr_d[i] = fifo_instr_q[i+1];
            fifo_pc_d[i]    = fifo_pc_q[i+1];
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (push && (count_after_pop == CW'(i))) begin
            fifo_instr_d[i] = bus.mem_data_out;
            fifo_pc_d[i]    = pc_q;
         end
      end
      count_d = count_after;

      case (state_q)
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (push) begin
               pc_d    = pc_q + 32'd4;
               state_d = (count_after < DEPTH_C) ? ISSUE : HOLD;
            end
         end
         HOLD: begin
            if (count_after_pop < DEPTH_C) state_d = ISSUE;
         end
         default: state_d = ISSUE;
      endcase

      // Redirect wins: any pop or response in this cycle is discarded with the flush.
      if (redirect) begin
         state_d      = ISSUE;
         pc_d         = {redirect_pc[31:2], 2'b00};
         count_d      = '0;
         fifo_instr_d = fifo_instr_q;
         fifo_pc_d    = fifo_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ISSUE;
         pc_q         <= RESET_PC;
         count_q      <= '0;
         // NOTE: the FIFO storage is reset, not just the count, because its head drives instr/instr_pc directly.
         fifo_instr_q <= '{default: '0};
         fifo_pc_q    <= '{default: '0};
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values together.
         state_q      <= state_d;
         pc_q         <= pc_d;
         count_q      <= count_d;
         fifo_instr_q <= fifo_instr_d;
         fifo_pc_q    <= fifo_pc_d;
      end
   end

   assign bus.mem_wr      = 1'b0;
   assign bus.mem_data_in = '0;
   assign bus.mem_addr    = pc_q;
   assign bus.instr_valid = (count_q != '0);
   assign bus.instr       = fifo_instr_q[0];
   assign bus.instr_pc    = fifo_pc_q[0];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-configurable memory model and a
// scoreboard queue of expected {pc, word} pairs compared on every decode pop.
module tb_fetch_unit;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_2000), .DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .redirect   (redirect),
      .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Memory: valid once the address has been stable for lat cycles.
   int          lat       = 1;
   int          stable    = 0;
   logic [31:0] last_addr = '0;

   always @(posedge clk) begin
      stable             <= (bus.mem_addr != last_addr) ? 0 : stable + 1;
      last_addr          <= bus.mem_addr;
      bus.mem_data_out   <= mem_word(bus.mem_addr);
      bus.mem_data_valid <= (((bus.mem_addr != last_addr) ? 0 : stable + 1) >= lat - 1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.word = mem_word(pc);
      exp_q.push_back(e);
   endtask

   // One cycle: drive inputs at the negedge, sample outputs, score any pop.
   task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
      exp_t e;
      @(negedge clk);
      bus.instr_ready = rdy;
      redirect        = redir;
      redirect_pc     = rpc;
      check("mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      check("mem_data_in", bus.mem_data_in, 32'd0);
      if (rst_n && bus.instr_valid && rdy && !redir) begin
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else e = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
         check("instr_pc", bus.instr_pc, e.pc);
         check("instr", bus.instr, e.word);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step(1'b1, 1'b0, 32'd0);
         n++;
      end
      check("drain_left", exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_values();
      check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_instr_pc", bus.instr_pc, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'h0000_2000);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n           = 1'b0;
      bus.instr_ready = 1'b0;
      redirect        = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst_n = 1'b1;
      check_reset_values();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = '0;
      bus.instr_ready = 1'b0;

      // Reset release: first instruction in cycle 2, next in cycle 4.
      apply_reset();
      push_exp(32'h2000);
      push_exp(32'h2004);
      step(1'b1, 1'b0, 32'd0);
      check("c1_valid", {31'd0, bus.instr_valid}, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      check("c2_valid", {31'd0, bus.instr_valid}, 32'd1);
      step(1'b1, 1'b0, 32'd0);
      check("c3_valid", {31'd0, bus.instr_valid}, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      check("c4_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("c4_queue", exp_q.size(), 32'd0);

      // Backpressure: exactly two entries fill, fetch parks at 0x2008.
      apply_reset();
      repeat (10) step(1'b0, 1'b0, 32'd0);
      check("full_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("full_head_pc", bus.instr_pc, 32'h2000);
      check("full_head", bus.instr, mem_word(32'h2000));
      check("hold_addr", bus.mem_addr, 32'h2008);
      for (int i = 0; i < 4; i++) push_exp(32'h2000 + 32'(4 * i));
      drain(40);

      // Redirect during an accepting WAIT drops the 0x3004 word.
      step(1'b1, 1'b1, 32'h3000);
      push_exp(32'h3000);
      step(1'b1, 1'b0, 32'd0);
      check("rd_issue_addr", bus.mem_addr, 32'h3000);
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      check("rd_first_valid", {31'd0, bus.instr_valid}, 32'd1);
      step(1'b1, 1'b1, 32'h2103);
      check("rd_wait_addr", bus.mem_addr, 32'h3004);
      check("rd_wait_empty", {31'd0, bus.instr_valid}, 32'd0);
      push_exp(32'h2100);
      push_exp(32'h2104);
      step(1'b1, 1'b0, 32'd0);
      check("rd_target_addr", bus.mem_addr, 32'h2100);
      check("rd_flushed", {31'd0, bus.instr_valid}, 32'd0);
      drain(20);

      // Three-cycle memory: address stable through the stall, one word per 4 cycles.
      lat = 3;
      step(1'b1, 1'b1, 32'h4000);
      for (int i = 0; i < 4; i++) push_exp(32'h4000 + 32'(4 * i));
      for (int k = 1; k <= 17; k++) begin
         step(1'b1, 1'b0, 32'd0);
         check($sformatf("lat_addr_k%0d", k), bus.mem_addr, 32'h4000 + 32'(4 * ((k - 1) / 4)));
         check($sformatf("lat_valid_k%0d", k), {31'd0, bus.instr_valid},
               {31'd0, ((k - 1) % 4 == 0) && (k > 1)});
      end
      check("lat_queue", exp_q.size(), 32'd0);
      lat = 1;

      // Redirect with a full FIFO flushes it; target wraps the PC.
      step(1'b0, 1'b1, 32'h6000);
      repeat (6) step(1'b0, 1'b0, 32'd0);
      check("pre_flush_valid", {31'd0, bus.instr_valid}, 32'd1);
      step(1'b1, 1'b1, 32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC);
      push_exp(32'h0000_0000);
      push_exp(32'h0000_0004);
      step(1'b1, 1'b0, 32'd0);
      check("wrap_flushed", {31'd0, bus.instr_valid}, 32'd0);
      check("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
      drain(20);

      // Asynchronous reset mid-WAIT with one buffered entry.
      step(1'b0, 1'b1, 32'h5000);
      repeat (4) step(1'b0, 1'b0, 32'd0);
      check("mid_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("mid_head_pc", bus.instr_pc, 32'h5000);
      check("mid_addr", bus.mem_addr, 32'h5004);
      #1 rst_n = 1'b0;
      #1;
      check("async_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("async_addr", bus.mem_addr, 32'h2000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reset_values();
      push_exp(32'h2000);
      push_exp(32'h2004);
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
